bus_master: RTL and testbench
=============================

# bus_master

Load/store initiator for the embedded SoC's shared peripheral bus (`mem_we`, `mem_addr`, tri-state `mem_data`). It accepts byte, halfword and word requests from the core over a valid/ready handshake and turns them into word-wide bus cycles. Sub-word stores are performed as read-modify-write, because the bus has no byte enables. It is the only bus driver on the write side, and the responders (RAM and other perips) only drive `mem_data` on reads.

## Interface
- `RD_WAIT`, default 0: extra wait cycles before `mem_data` is sampled on a read (0 = sample at the end of the first read cycle).

- `clk`  in  1  system clock, all state on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  misaligned or illegal-size request; valid with `rsp_valid`.
- `mem_we`  out  1  bus write strobe.
- `mem_addr`  out  32  word-aligned bus address ([1:0] = 00).
- `mem_data`  inout  32  driven only while `mem_we`=1, otherwise high-Z.

## Operation
- States: IDLE, RD, WR, RSP.
- IDLE
  - `req_ready`=1.
  - When `req_valid && req_ready` at an edge, latch `req_*` and the lane = `addr[1:0]`.
- Error check at accept:
  - size 11, half with `addr[0]`=1, or word with `addr[1:0]`≠0 → RSP with `rsp_err`=1.
  - No bus activity occurs for an error.
- Load: go to RD.
- Word store: go to WR.
- Byte/half store: go to RD, then WR.
- RD
  - `mem_we`=0, `mem_addr`={`addr[31:2]`,00}.
  - Stay 1+`RD_WAIT` cycles (wait counter), then sample `mem_data` on the final edge.
  - Load: extract and extend the sampled data into `rsp_rdata`, go to RSP.
    - Byte = `data[8*lane+:8]`.
    - Half = `data[16*lane[1]+:16]`.
    - Little-endian.
  - Sub-word store: merge `req_wdata` into the sampled word at the lane, leaving other bytes unchanged, then go to WR.
- WR
  - Exactly one cycle: `mem_we`=1, `mem_addr` word-aligned, `mem_data` driven with the full or merged word.
  - Then go to RSP.
- RSP
  - `rsp_valid`=1 for one cycle, then IDLE.
  - `rsp_rdata` and `rsp_err` hold their values until the next RSP.
- Outside RD and WR, `mem_addr`=0 and `mem_we`=0.
- Sampled bus data that is Z/X is not masked. Responders are responsible for driving valid data.
- `req_*` inputs are ignored outside the accept edge. Changing them mid-transaction has no effect.

## Timing
- Reset (`rst`=0), applied immediately:
  - state IDLE, `req_ready`=0.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - `mem_we`=0, `mem_addr`=0, `mem_data` high-Z.
- After `rst` is released: `req_ready`=1 from the first cycle.
- Latency, counted from the accept edge E0 to the cycle in which `rsp_valid` is high:
  - word/sub-word load: 2+`RD_WAIT`.
  - word store: 2.
  - sub-word store: 3+`RD_WAIT`.
  - error: 1.
- `req_ready`=0 from the cycle after E0 until the block is back in IDLE.
  - A request held valid during RSP is accepted on the first IDLE edge, so back-to-back issue is possible.
  - There is at most one outstanding request.
- `mem_data` is released to Z in the same cycle `mem_we` falls, so no two drivers overlap.
- Reset mid-transaction aborts the request:
  - `mem_we` drops asynchronously.
  - No `rsp_valid` is produced.
  - A partial RMW never writes.

## Test plan
- Reset: hold `rst`=0 with `req_valid`=1 → `req_ready`=0, `mem_we`=0, `mem_data`=Z, `rsp_valid`=0. After release, `req_ready`=1 the next cycle.
- Word store 0xDEADBEEF @0x10 → one cycle `mem_we`=1, `mem_addr`=0x10, `rsp_valid` at E0+2. Word load @0x10 → `rsp_rdata`=0xDEADBEEF, `rsp_err`=0, latency 2.
- RAM word @0x10 = 0x11223344, byte store 0xA5 @0x13 → RD then WR of 0xA5223344.
  - Signed byte load @0x13 → 0xFFFFFFA5.
  - Unsigned byte load @0x13 → 0x000000A5.
- Word 0x8000_1234 @0x20:
  - Signed half load @0x22 → 0xFFFF8000.
  - Unsigned half load @0x20 → 0x00001234.
  - Half store 0xBEEF @0x22 → word becomes 0xBEEF1234.
- Word load @0x06, half store @0x01, size 11 → each gives `rsp_err`=1, `rsp_rdata`=0, latency 1, `mem_we` never asserted.
- `RD_WAIT`=2:
  - Word load latency 4.
  - `rst` pulled low during the WR of a byte store → `mem_we` falls immediately, memory unchanged, no `rsp_valid`.
  - A subsequent request completes normally.

Source files
------------

// File: rtl/bus_master.sv
// Load/store initiator for the shared peripheral bus: word bus cycles from
// byte/half/word core requests, with read-modify-write for sub-word stores.
module bus_master #(
  parameter int RD_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  inout  wire  [31:0] mem_data
);

  localparam int WCW = (RD_WAIT > 0) ? $clog2(RD_WAIT + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(RD_WAIT);

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            we_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [31:0]     addr_q;
  logic [15:0]     wdata_q;
  logic [31:0]     wr_word;
  logic [WCW-1:0]  wait_cnt;
  logic            accept;
  logic            req_bad;
  logic            rd_last;

  function automatic logic bad_req(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = lane[0];
      2'b10:   bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Little-endian lane extraction with sign or zero extension.
  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00: begin
        if (uns) r = {24'd0, b};
        else     r = 32'(b);
      end
      2'b01: begin
        if (uns) r = {16'd0, h};
        else     r = 32'(h);
      end
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [15:0] wd,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size);
    logic [31:0] r;
    r = word;
    if (size == 2'b00) begin
      case (lane)
        2'd0:    r[7:0]   = wd[7:0];
        2'd1:    r[15:8]  = wd[7:0];
        2'd2:    r[23:16] = wd[7:0];
        default: r[31:24] = wd[7:0];
      endcase
    end else if (lane[1]) begin
      r[31:16] = wd;
    end else begin
      r[15:0] = wd;
    end
    return r;
  endfunction

  // Reset is folded into ready only at the port; internally the async reset
  // of the state register already dominates any accept.
  assign accept    = (state == IDLE) && req_valid;
  assign req_ready = (state == IDLE) && rst;
  assign req_bad   = bad_req(req_size, req_addr[1:0]);
  assign rd_last   = (state == RD) && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_bad)                          state_nxt = RSP;
          else if (!req_we || req_size != 2'b10) state_nxt = RD;
          else                                  state_nxt = WR;
        end
      end
      RD:      if (rd_last) state_nxt = we_q ? WR : RSP;
      WR:      state_nxt = RSP;
      RSP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (state != RD)   wait_cnt <= '0;
      else if (!rd_last) wait_cnt <= wait_cnt + 1'b1;

      if (accept && req_bad) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end else if (rd_last && !we_q) begin
        rsp_rdata <= extract_load(mem_data, addr_q[1:0], size_q, uns_q);
        rsp_err   <= 1'b0;
      end else if (state == WR) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end

  // Request capture and write word: pure data, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      wdata_q <= req_wdata[15:0];
      wr_word <= req_wdata;
    end else if (rd_last && we_q) begin
      wr_word <= merge_store(mem_data, wdata_q, addr_q[1:0], size_q);
    end
  end

  assign rsp_valid = (state == RSP);
  assign mem_we    = (state == WR);
  assign mem_addr  = (state == RD || state == WR) ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_data  = (state == WR) ? wr_word : 32'bz;

endmodule

// File: tb/tb_bus_master.sv
// Scoreboard bench for bus_master: one instance with RD_WAIT=0, one with RD_WAIT=2.
module tb_bus_master;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid0 = 1'b0;
  logic        req_valid1 = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;

  logic        req_ready0, rsp_valid0, rsp_err0, mem_we0;
  logic        req_ready1, rsp_valid1, rsp_err1, mem_we1;
  logic [31:0] rsp_rdata0, mem_addr0, rsp_rdata1, mem_addr1;
  wire  [31:0] bus0;
  wire  [31:0] bus1;

  logic [31:0] ram0 [16];
  logic [31:0] ram1 [16];
  int          wr_cnt0 = 0;
  int          wr_cnt1 = 0;
  logic [31:0] last_waddr0 = 32'd0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        e0, e1;

  always #5 clk = ~clk;

  bus_master #(.RD_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid0),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .mem_we(mem_we0),
    .mem_addr(mem_addr0), .mem_data(bus0)
  );

  bus_master #(.RD_WAIT(2)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid1),
    .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1), .mem_we(mem_we1),
    .mem_addr(mem_addr1), .mem_data(bus1)
  );

  // RAM responders drive the bus only while the master is not writing.
  assign bus0 = !mem_we0 ? ram0[mem_addr0[5:2]] : 32'bz;
  assign bus1 = !mem_we1 ? ram1[mem_addr1[5:2]] : 32'bz;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_we0) begin
      ram0[mem_addr0[5:2]] <= bus0;
      wr_cnt0 <= wr_cnt0 + 1;
      last_waddr0 <= mem_addr0;
    end
    if (mem_we1) begin
      ram1[mem_addr1[5:2]] <= bus1;
      wr_cnt1 <= wr_cnt1 + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic note_fail(input string name);
    n_checks++;
    $display("FAIL %s: bound expired", name);
  endtask

  always @(negedge clk) begin
    if (rsp_valid0) begin
      if (q0.size() == 0) begin
        note_fail("dut0_unexpected_rsp");
      end else begin
        e0 = q0.pop_front();
        chk("dut0_rdata", rsp_rdata0, e0.rdata);
        chk("dut0_err", 32'(rsp_err0), 32'(e0.err));
        chk("dut0_latency", 32'(cyc - e0.acc), 32'(e0.lat));
      end
    end
  end

  always @(negedge clk) begin
    if (rsp_valid1) begin
      if (q1.size() == 0) begin
        note_fail("dut1_unexpected_rsp");
      end else begin
        e1 = q1.pop_front();
        chk("dut1_rdata", rsp_rdata1, e1.rdata);
        chk("dut1_err", 32'(rsp_err1), 32'(e1.err));
        chk("dut1_latency", 32'(cyc - e1.acc), 32'(e1.lat));
      end
    end
  end

  task automatic issue(input int inst, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] er, input logic ee, input int el, input bit push);
    exp_t e;
    int   n;
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    if (inst == 0) req_valid0 = 1'b1;
    else           req_valid1 = 1'b1;
    n = 0;
    while (!(inst == 0 ? req_ready0 : req_ready1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      note_fail("accept_timeout");
      req_valid0 = 1'b0;
      req_valid1 = 1'b0;
      return;
    end
    e.rdata = er; e.err = ee; e.lat = el; e.acc = cyc;
    if (push) begin
      if (inst == 0) q0.push_back(e);
      else           q1.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;
  endtask

  task automatic wait_idle(input int inst);
    int n;
    n = 0;
    while ((inst == 0 ? q0.size() : q1.size()) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) note_fail("rsp_timeout");
    @(negedge clk);
  endtask

  initial begin
    int w;
    int n;
    // reset held with a request pending
    #2;
    rst = 1'b0;
    req_valid0 = 1'b1;
    req_valid1 = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready0", 32'(req_ready0), 32'd0);
    chk("rst_mem_we0", 32'(mem_we0), 32'd0);
    chk("rst_rsp_valid0", 32'(rsp_valid0), 32'd0);
    chk("rst_rdata0", rsp_rdata0, 32'd0);
    chk("rst_err0", 32'(rsp_err0), 32'd0);
    chk("rst_mem_addr0", mem_addr0, 32'd0);
    chk("rst_ready1", 32'(req_ready1), 32'd0);
    chk("rst_mem_we1", 32'(mem_we1), 32'd0);
    rst = 1'b1;
    #1;
    chk("post_rst_ready0", 32'(req_ready0), 32'd1);
    chk("post_rst_ready1", 32'(req_ready1), 32'd1);
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;

    // RD_WAIT = 0 instance
    w = wr_cnt0;
    issue(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1);
    wait_idle(0);
    chk("wstore_writes", 32'(wr_cnt0 - w), 32'd1);
    chk("wstore_addr", last_waddr0, 32'h10);
    chk("wstore_mem", ram0[4], 32'hDEADBEEF);
    issue(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1);
    issue(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0, 2, 1'b1);
    issue(0, 1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFFFFA5, 32'h0, 1'b0, 3, 1'b1);
    wait_idle(0);
    chk("bstore_mem", ram0[4], 32'hA5223344);
    issue(0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFFA5, 1'b0, 2, 1'b1);
    issue(0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h000000A5, 1'b0, 2, 1'b1);
    issue(0, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h00000033, 1'b0, 2, 1'b1);
    issue(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h80001234, 32'h0, 1'b0, 2, 1'b1);
    issue(0, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'hFFFF8000, 1'b0, 2, 1'b1);
    issue(0, 1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 32'h00001234, 1'b0, 2, 1'b1);
    issue(0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, 32'h0, 1'b0, 3, 1'b1);
    wait_idle(0);
    chk("hstore_mem", ram0[8], 32'hBEEF1234);
    chk("hstore_addr", last_waddr0, 32'h20);
    issue(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hBEEF1234, 1'b0, 2, 1'b1);

    // illegal requests: no bus write, rdata cleared
    w = wr_cnt0;
    issue(0, 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    issue(0, 1'b1, 2'b01, 1'b0, 32'h01, 32'h5555, 32'h0, 1'b1, 1, 1'b1);
    issue(0, 1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    wait_idle(0);
    chk("err_no_writes", 32'(wr_cnt0 - w), 32'd0);
    chk("err_mem_intact", ram0[8], 32'hBEEF1234);

    // RD_WAIT = 2 instance
    issue(1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1'b1);
    issue(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0, 4, 1'b1);
    issue(1, 1'b1, 2'b01, 1'b0, 32'h10, 32'h00001111, 32'h0, 1'b0, 5, 1'b1);
    wait_idle(1);
    chk("wait_hstore_mem", ram1[4], 32'hCAFE1111);

    // abort a byte store during its write cycle
    w = wr_cnt1;
    issue(1, 1'b1, 2'b00, 1'b0, 32'h11, 32'h00000077, 32'h0, 1'b0, 0, 1'b0);
    n = 0;
    while (!mem_we1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) note_fail("abort_wr_timeout");
    rst = 1'b0;
    #1;
    chk("abort_we_drop", 32'(mem_we1), 32'd0);
    chk("abort_addr_zero", mem_addr1, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_write", 32'(wr_cnt1 - w), 32'd0);
    chk("abort_mem", ram1[4], 32'hCAFE1111);
    issue(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hCAFE1111, 1'b0, 4, 1'b1);
    wait_idle(1);

    repeat (3) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
